// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the mux round-robin arbiter.
// Optional feature macro used by the arbiter: MUX_ARB_LOCK_EN.
package mux_arb_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultN     = 4;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request strictly after last_gnt_i, with wrap.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned SelW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SelW-1:0] last_gnt_i,
  output logic [N-1:0]    gnt_o,
  output logic [SelW-1:0] idx_o
);

  int unsigned     cand;
  logic [SelW-1:0] cand_idx;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // The offset runs 1..N so the previous winner is scanned last.
    for (int unsigned off = 1; off <= N; off++) begin
      cand     = (32'(last_gnt_i) + off) % N;
      cand_idx = cand[SelW-1:0];
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a registered valid/ready output stage from N requester words.
// Define MUX_ARB_LOCK_EN to add the lock input, which re-grants the current owner for bursts.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N     = DefaultN,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]       lock,
`endif
  output logic [N-1:0]       ack,
  output logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  input  logic               y_ready
);

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_gnt_q, last_gnt_d;

  logic [N-1:0]     rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     sel_onehot;
  logic [N-1:0]     win_gnt;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_word;
  logic             load;
  logic             lock_hit;

  rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (rr_gnt),
    .idx_o      (rr_idx)
  );

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[sel_q] = 1'b1;
`ifdef MUX_ARB_LOCK_EN
    // Only the word actually being consumed can hold the grant.
    lock_hit = (state_q == StBusy) && lock[sel_q] && req[sel_q];
`else
    lock_hit = 1'b0;
`endif
    load    = (|req) && ((state_q == StIdle) || y_ready);
    win_idx = lock_hit ? sel_q : rr_idx;
    win_gnt = lock_hit ? sel_onehot : rr_gnt;

    win_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_idx == SEL_W'(i)) begin
        win_word = data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    ack        = '0;
    if (load) begin
      state_d = StBusy;
      y_d     = win_word;
      sel_d   = win_idx;
      ack     = win_gnt;
      if (!lock_hit) begin
        last_gnt_d = win_idx;
      end
    end else if (state_q == StBusy && y_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      y_q        <= '0;
      sel_q      <= '0;
      last_gnt_q <= SEL_W'(N - 1);
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign y       = y_q;
  assign sel     = sel_q;
  assign y_valid = (state_q == StBusy);

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 mux datapath between N requesters, each presenting a data word.
- Picks one requester, drives the mux select, and registers the selected word into a valid/ready output stage.
- Sits between the producer agents and the downstream consumer (e.g. a FIFO write port).

Parameters:
- WIDTH, 4, data width per requester and on the output.
- N, 4, number of requesters; legal range 2..16.
- SEL_W, $clog2(N), select/index width; localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request; held high while data is valid.
- data  input  N*WIDTH  packed requester words; requester i occupies bits [i*WIDTH +: WIDTH].
- ack  output  N  one-hot, one-cycle pulse; the word from requester i was captured this edge.
- sel  output  SEL_W  index of the requester whose word is currently in y.
- y  output  WIDTH  registered output word.
- y_valid  output  1  y holds an unconsumed word.
- y_ready  input  1  consumer accepts y when y_valid && y_ready.

Behaviour:
- Reset (async assert, sync release): y=0, y_valid=0, ack=0, sel=0, last_gnt=N-1, state=IDLE. Requester 0 has priority after reset.
- Two states:
  - IDLE: y_valid=0.
  - BUSY: y_valid=1; y and sel held stable until the handshake.
- Load event: state==IDLE && |req, or state==BUSY && y_ready && |req.
  - Winner = first i with req[i]=1, scanning (last_gnt+1) mod N upward with wrap.
  - On the edge: y<=data[winner], sel<=winner, last_gnt<=winner, ack[winner]=1 for exactly that cycle, state<=BUSY.
- IDLE with no req: stay IDLE.
- BUSY without y_ready: hold everything; ack=0; req changes are ignored.
- BUSY, y_ready, no req: y_valid<=0, state<=IDLE; y retains its last value.
- Timing: latency req→y_valid is 1 cycle. Back-to-back throughput is 1 word/cycle when y_ready is held high.
- Requester handshake:
  - A requester keeps req high until it sees ack.
  - Deasserting req before ack withdraws the request; no capture occurs.
  - req still high after ack means a new word is queued for a later turn.
- Fairness: with all req high, grants cycle 0,1,2,3,0,… No requester waits more than N-1 grants.
- Single requester: it is re-granted every transfer.
- ack is combinational from state, y_ready, req and last_gnt. It is at most one-hot and is asserted only on load-event cycles.
- Reset asserted mid-transfer: y_valid drops immediately and any pending word is discarded.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds input lock[N-1:0].
  - If the word being consumed came from requester k, and lock[k] && req[k] at the load event, k is re-granted, bypassing the round-robin scan. last_gnt is unchanged.
  - Used for atomic bursts.
- Undefined: no lock port; pure round-robin.

Decomposition:
- Package mux_arb_pkg holds the arb_state_e typedef (IDLE, BUSY) and the default WIDTH/N constants.
- One sub-module, rr_pick:
  - Combinational; inputs req and last_gnt; outputs a one-hot grant and an encoded index.
  - Reusable by other arbiters in the bench environment.

Test Plan:
- Reset, then req=4'b0001, data0=4'hA, y_ready=1 → next cycle y=A, sel=0, y_valid=1; ack[0] pulsed in the load cycle.
- req=4'b1111, data words 1/2/3/4, y_ready=1 → y sequence 1,2,3,4,1 on consecutive cycles; sel sequence 0,1,2,3,0.
- req=4'b0101, y_ready=0 for 3 cycles after the first load → y=data0 held stable, ack=0 throughout. On y_ready=1, y switches to data2 the next cycle.
- last_gnt=3, req=4'b1001 → requester 0 granted (wrap-around), then requester 3.
- rst_n pulled low while y_valid=1 → y_valid=0, y=0, sel=0 asynchronously. After release, req=4'b0010 → requester 1 is granted.
- MUX_ARB_LOCK_EN, req=4'b0011, lock=4'b0001 → requester 0 granted three times consecutively. Clearing lock makes the next grant go to requester 1.
